dma_burst_ctrl: RTL

//  Parametrised single-channel memory-to-memory DMA engine; successor to the word-at-a-time copier.

---
 rtl/dma_burst_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/dma_burst_ctrl.sv
// Single-channel memory-to-memory DMA engine: bursts of up to BURST words through an internal FIFO.
// Optional DMA_IRQ_EN adds a sticky completion interrupt (irq / irq_clr).
module dma_burst_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              src_inc,
  input  logic              dst_inc,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
`ifdef DMA_IRQ_EN
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              irq,
  input  logic              irq_clr
`else
  input  logic [DATA_W-1:0] mem_rdata
`endif
);

  localparam int IDX_W = $clog2(BURST);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

  typedef enum logic [2:0] {IDLE, RD, RD_DRAIN, WR, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [LEN_W-1:0]  remaining;
  logic              src_inc_q;
  logic              dst_inc_q;
  logic              abort_q;
  logic              end_aborted;
  logic [CNT_W-1:0]  nb;
  logic [CNT_W-1:0]  issued_cnt;
  logic [CNT_W-1:0]  recv_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [DATA_W-1:0] fifo [BURST];

  logic              abort_eff;
  logic              push;
  logic              issued_last;
  logic              wr_last;
  logic [ADDR_W-1:0] src_next;
  logic [ADDR_W-1:0] dst_next;
  logic [LEN_W-1:0]  rem_after;
  logic [IDX_W-1:0]  wr_idx_next;

  function automatic logic [CNT_W-1:0] burst_len(input logic [LEN_W-1:0] r);
    if (r >= LEN_W'(BURST)) burst_len = CNT_W'(BURST);
    else                    burst_len = CNT_W'(r);
  endfunction

  assign abort_eff   = abort_q | abort;
  assign push        = ((state == RD) || (state == RD_DRAIN)) && mem_rvalid;
  assign issued_last = (issued_cnt + CNT_W'(1)) == nb;
  assign wr_last     = (wr_cnt + CNT_W'(1)) == nb;
  assign src_next    = src_ptr + (src_inc_q ? STEP : '0);
  assign dst_next    = dst_ptr + (dst_inc_q ? STEP : '0);
  assign rem_after   = remaining - LEN_W'(nb);
  assign wr_idx_next = wr_cnt[IDX_W-1:0] + IDX_W'(1);

  // Each burst refills the FIFO from index 0, so the receive count is the write index
  always_ff @(posedge clk) begin
    if (push) fifo[recv_cnt[IDX_W-1:0]] <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      remaining   <= '0;
      src_inc_q   <= 1'b0;
      dst_inc_q   <= 1'b0;
      abort_q     <= 1'b0;
      end_aborted <= 1'b0;
      nb          <= '0;
      issued_cnt  <= '0;
      recv_cnt    <= '0;
      wr_cnt      <= '0;
    end else begin
      if (busy && abort) abort_q <= 1'b1;
      if (push) recv_cnt <= recv_cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          done    <= 1'b0;
          aborted <= 1'b0;
          abort_q <= 1'b0;
          if (start) begin
            busy        <= 1'b1;
            src_ptr     <= src_addr;
            dst_ptr     <= dest_addr;
            remaining   <= len;
            src_inc_q   <= src_inc;
            dst_inc_q   <= dst_inc;
            end_aborted <= 1'b0;
            nb          <= burst_len(len);
            issued_cnt  <= '0;
            recv_cnt    <= '0;
            wr_cnt      <= '0;
            if (len == '0) begin
              state <= DONE;
            end else begin
              state     <= RD;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= src_addr;
              mem_wdata <= '0;
            end
          end
        end

        // Once abort is seen, the granted read is the last one; outstanding data still drains
        RD: begin
          if (mem_gnt) begin
            issued_cnt <= issued_cnt + CNT_W'(1);
            src_ptr    <= src_next;
            if (issued_last || abort_eff) begin
              mem_req <= 1'b0;
              state   <= RD_DRAIN;
            end else begin
              mem_addr <= src_next;
            end
          end
        end

        RD_DRAIN: begin
          if (recv_cnt == issued_cnt) begin
            if (abort_eff) begin
              end_aborted <= 1'b1;
              state       <= DONE;
            end else begin
              state     <= WR;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= dst_ptr;
              mem_wdata <= fifo[0];
            end
          end
        end

        // A final write grant completes normally even if abort arrives with it
        WR: begin
          if (mem_gnt) begin
            wr_cnt  <= wr_cnt + CNT_W'(1);
            dst_ptr <= dst_next;
            if (wr_last) begin
              remaining <= rem_after;
              if (rem_after == '0) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                state   <= DONE;
              end else if (abort_eff) begin
                mem_req     <= 1'b0;
                mem_we      <= 1'b0;
                end_aborted <= 1'b1;
                state       <= DONE;
              end else begin
                state      <= RD;
                mem_req    <= 1'b1;
                mem_we     <= 1'b0;
                mem_addr   <= src_ptr;
                mem_wdata  <= '0;
                nb         <= burst_len(rem_after);
                issued_cnt <= '0;
                recv_cnt   <= '0;
                wr_cnt     <= '0;
              end
            end else if (abort_eff) begin
              mem_req     <= 1'b0;
              mem_we      <= 1'b0;
              end_aborted <= 1'b1;
              state       <= DONE;
            end else begin
              mem_addr  <= dst_next;
              mem_wdata <= fifo[wr_idx_next];
            end
          end
        end

        DONE: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          aborted <= end_aborted;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMA_IRQ_EN
  // Set is taken on the same edge that raises done, and overrides a concurrent clear
  always_ff @(posedge clk) begin
    if (rst)                irq <= 1'b0;
    else if (state == DONE) irq <= 1'b1;
    else if (irq_clr)       irq <= 1'b0;
  end
`endif

endmodule
